branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
- REQ-001: Parameter DEPTH, default 8, in-flight branch entries; power of two, at least 2.
- REQ-002: Parameter IDXW, default 10, PHT index width.
- REQ-003: Parameter HISTW, default 10, global history width.
- REQ-004: clk  in  1  single clock; every flop on rising edge.
- REQ-005: reset  in  1  asynchronous, active-high reset.
- REQ-006: alloc_valid  in  1  front end has a predicted branch to enqueue.
- REQ-007: alloc_ready  out  1  entry free; equals (count < DEPTH), combinational.
- REQ-008: alloc_taken  in  1  predicted direction.
- REQ-009: alloc_idx  in  IDXW  PHT index used for the prediction (history XOR address).
- REQ-010: alloc_hist  in  HISTW  global history at prediction time.
- REQ-011: alloc_tag  out  log2(DEPTH)  tag granted to the current allocation; equals the tail pointer.
- REQ-012: res_valid, res_tag, res_taken  in  1, log2(DEPTH), 1  execute-stage resolution; may arrive out of order.
- REQ-013: upd_valid, upd_idx, upd_taken  out  1, IDXW, 1  in-order predictor training port.
- REQ-014: flush, flush_hist  out  1, HISTW  mispredict redirect and corrected history.
- REQ-015: empty  out  1  count == 0.

Function
- REQ-016: Circular buffer; head, tail and count registers; pointers wrap modulo DEPTH.
- REQ-017: Allocation fires when alloc_valid && alloc_ready; the entry stores taken, idx and hist, is marked valid and unresolved, and tail advances by 1.
- REQ-018: A resolution to a valid, unresolved entry marks it resolved and stores res_taken; a resolution to an invalid or already-resolved entry is ignored.
- REQ-019: Mispredict is a qualifying resolution where res_taken != the stored prediction.
- REQ-020: On a mispredict, the next cycle has flush=1 for exactly one cycle and flush_hist={stored hist[HISTW-2:0], res_taken}.
- REQ-021: On a mispredict, all entries younger than res_tag are invalidated in the same edge, tail becomes res_tag+1, and count is recomputed.
- REQ-022: An allocation in the same cycle as a mispredicting resolution is discarded, and tail does not advance for it.
- REQ-023: Retire happens when the head entry is valid and resolved; the next cycle has upd_valid=1, upd_idx equal to the stored idx, and upd_taken equal to the resolved outcome; head advances and count decrements.
- REQ-024: At most one retire per cycle; a resolution reaches the retire logic no earlier than the following cycle, so minimum resolve-to-update latency is 2 cycles.
- REQ-025: Simultaneous allocate and retire leaves count unchanged; full and retire in one cycle does not let that cycle's allocation in, because alloc_ready is based on the current count.
- REQ-026: A mispredicted entry still retires and trains the predictor with its actual outcome.
- REQ-027: When upd_valid=0, upd_idx and upd_taken hold their last values.

Reset
- REQ-028: Reset is asynchronous: head=tail=count=0, every entry invalid, upd_valid=0, upd_idx=0, upd_taken=0, flush=0, flush_hist=0, empty=1, alloc_ready=1.
- REQ-029: Reset during operation drops all in-flight entries; no update or flush is issued for them after reset deasserts.

Configuration
- REQ-030: With BRQ_STATS_EN defined, outputs stat_branches and stat_mispred (32 bits each, wrapping, reset to 0) are present; they count retires and mispredicts respectively.
- REQ-031: Without BRQ_STATS_EN, those ports and counters do not exist, and all other behaviour is identical.

Verification
- REQ-032: Allocate three entries (tags 0,1,2, all predicted taken), then resolve tag 2, 0, 1 taken on consecutive cycles -> updates appear in order for tags 0, 1, 2; no flush.
- REQ-033: Allocate 8 entries -> alloc_ready=0; a further alloc_valid is ignored; retiring tag 0 sets alloc_ready=1 the following cycle.
- REQ-034: Allocate tags 0-3, tag 1 with hist=10'h155 and predicted taken; resolve tag 1 not-taken -> next cycle flush=1 and flush_hist=10'h2AA; tags 2 and 3 invalidated; tail=2.
- REQ-035: Mispredicting resolve together with alloc_valid=1 -> allocation dropped; a later resolution to the dropped tag is ignored.
- REQ-036: Allocate 10 entries with a retire interleaved so the tail wraps from 7 to 0 -> tags and update order stay correct across the wrap.
- REQ-037: Assert reset with 5 entries in flight -> empty=1 immediately; no upd_valid or flush after release; with BRQ_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//   Tracks in-flight predicted branches in a circular buffer. Branches are
//   resolved out of order by the execute stage and retired in order to train
//   the direction predictor. A resolution that disagrees with the stored
//   prediction squashes all younger entries and emits a one-cycle flush with
//   the corrected global history.
//
// Ports
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_alloc_valid/_taken/_idx/_hist, o_alloc_ready, o_alloc_tag
//                          enqueue of a predicted branch; tag = tail pointer
//   i_res_valid/_tag/_taken
//                          execute-stage resolution (any order)
//   o_upd_valid/_idx/_taken
//                          in-order predictor training, one per cycle
//   o_flush, o_flush_hist  mispredict redirect and corrected history
//   o_empty                no entries in flight
//   o_stat_branches, o_stat_mispred
//                          retire / mispredict counters, only when the
//                          BRQ_STATS_EN macro is defined
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDXW  = 10,
   parameter int unsigned HISTW = 10,
   localparam int unsigned TAGW = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_alloc_valid,
   output logic             o_alloc_ready,
   input  logic             i_alloc_taken,
   input  logic [IDXW-1:0]  i_alloc_idx,
   input  logic [HISTW-1:0] i_alloc_hist,
   output logic [TAGW-1:0]  o_alloc_tag,
   input  logic             i_res_valid,
   input  logic [TAGW-1:0]  i_res_tag,
   input  logic             i_res_taken,
   output logic             o_upd_valid,
   output logic [IDXW-1:0]  o_upd_idx,
   output logic             o_upd_taken,
   output logic             o_flush,
   output logic [HISTW-1:0] o_flush_hist,
   output logic             o_empty
`ifdef BRQ_STATS_EN
   ,
   output logic [31:0]      o_stat_branches,
   output logic [31:0]      o_stat_mispred
`endif
);

   localparam int unsigned CNTW = TAGW + 1;

   // Per-entry state
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_resolved;
   logic [DEPTH-1:0] r_pred;
   logic [DEPTH-1:0] r_actual;
   logic [IDXW-1:0]  r_idx  [DEPTH];
   logic [HISTW-1:0] r_hist [DEPTH];

   logic [TAGW-1:0]  r_head;
   logic [TAGW-1:0]  r_tail;
   logic [CNTW-1:0]  r_count;

   logic             r_upd_valid;
   logic [IDXW-1:0]  r_upd_idx;
   logic             r_upd_taken;
   logic             r_flush;
   logic [HISTW-1:0] r_flush_hist;

   logic             w_alloc_ready;
   logic             w_alloc;
   logic             w_res_fire;
   logic             w_mispred;
   logic             w_retire;
   logic [TAGW-1:0]  w_res_off;
   logic [DEPTH-1:0] w_younger;
   logic [TAGW-1:0]  w_head_d;
   logic [TAGW-1:0]  w_tail_d;
   logic [CNTW-1:0]  w_count_d;

   assign w_alloc_ready = (r_count < CNTW'(DEPTH));
   assign w_res_fire    = i_res_valid & r_valid[i_res_tag] & ~r_resolved[i_res_tag];
   assign w_mispred     = w_res_fire & (i_res_taken != r_pred[i_res_tag]);
   // A mispredicting resolution redirects the front end, so whatever it is
   // offering this cycle is on the wrong path.
   assign w_alloc       = i_alloc_valid & w_alloc_ready & ~w_mispred;
   // Only registered resolution state is seen here, which gives the
   // two-cycle minimum resolve-to-update latency.
   assign w_retire      = r_valid[r_head] & r_resolved[r_head];
   // Age of the resolving entry relative to head (0 = oldest).
   assign w_res_off     = i_res_tag - r_head;

   // Entries older-than-head distance beyond the resolving entry are younger
   // than it. Slots outside the live window are already invalid.
   always_comb begin
      w_younger = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((TAGW'(i) - r_head) > w_res_off) begin
            w_younger[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_head_d  = r_head;
      w_tail_d  = r_tail;
      w_count_d = r_count;
      if (w_retire) begin
         w_head_d = r_head + TAGW'(1);
      end
      if (w_mispred) begin
         // Survivors are head..res_tag inclusive; the mispredicted entry is
         // unresolved so it cannot be the one retiring this cycle.
         w_tail_d  = i_res_tag + TAGW'(1);
         w_count_d = {1'b0, w_res_off} + CNTW'(1) - CNTW'(w_retire);
      end else begin
         if (w_alloc) begin
            w_tail_d  = r_tail + TAGW'(1);
            w_count_d = w_count_d + CNTW'(1);
         end
         if (w_retire) begin
            w_count_d = w_count_d - CNTW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_valid      <= '0;
         r_resolved   <= '0;
         r_pred       <= '0;
         r_actual     <= '0;
         r_upd_valid  <= 1'b0;
         r_upd_idx    <= '0;
         r_upd_taken  <= 1'b0;
         r_flush      <= 1'b0;
         r_flush_hist <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_idx[i]  <= '0;
            r_hist[i] <= '0;
         end
      end else begin
         r_head  <= w_head_d;
         r_tail  <= w_tail_d;
         r_count <= w_count_d;

         for (int i = 0; i < DEPTH; i++) begin
            if (w_retire && (TAGW'(i) == r_head)) begin
               r_valid[i] <= 1'b0;
            end
            if (w_mispred && w_younger[i]) begin
               r_valid[i] <= 1'b0;
            end
            if (w_alloc && (TAGW'(i) == r_tail)) begin
               r_valid[i]    <= 1'b1;
               r_resolved[i] <= 1'b0;
               r_pred[i]     <= i_alloc_taken;
               r_idx[i]      <= i_alloc_idx;
               r_hist[i]     <= i_alloc_hist;
            end
            if (w_res_fire && (TAGW'(i) == i_res_tag)) begin
               r_resolved[i] <= 1'b1;
               r_actual[i]   <= i_res_taken;
            end
         end

         r_upd_valid <= w_retire;
         if (w_retire) begin
            r_upd_idx   <= r_idx[r_head];
            r_upd_taken <= r_actual[r_head];
         end

         r_flush <= w_mispred;
         if (w_mispred) begin
            r_flush_hist <= {r_hist[i_res_tag][HISTW-2:0], i_res_taken};
         end
      end
   end

`ifdef BRQ_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispred;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else begin
         if (w_retire) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispred) begin
            r_stat_mispred <= r_stat_mispred + 32'd1;
         end
      end
   end

   assign o_stat_branches = r_stat_branches;
   assign o_stat_mispred  = r_stat_mispred;
`endif

   assign o_alloc_ready = w_alloc_ready;
   assign o_alloc_tag   = r_tail;
   assign o_upd_valid   = r_upd_valid;
   assign o_upd_idx     = r_upd_idx;
   assign o_upd_taken   = r_upd_taken;
   assign o_flush       = r_flush;
   assign o_flush_hist  = r_flush_hist;
   assign o_empty       = (r_count == '0);

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_queue
//   Directed self-checking bench for branch_resolve_queue (default sizes).
//   Stats ports are connected and checked when BRQ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_alloc_valid;
   logic       o_alloc_ready;
   logic       i_alloc_taken;
   logic [9:0] i_alloc_idx;
   logic [9:0] i_alloc_hist;
   logic [2:0] o_alloc_tag;
   logic       i_res_valid;
   logic [2:0] i_res_tag;
   logic       i_res_taken;
   logic       o_upd_valid;
   logic [9:0] o_upd_idx;
   logic       o_upd_taken;
   logic       o_flush;
   logic [9:0] o_flush_hist;
   logic       o_empty;
`ifdef BRQ_STATS_EN
   logic [31:0] o_stat_branches;
   logic [31:0] o_stat_mispred;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_queue #(
      .DEPTH (8),
      .IDXW  (10),
      .HISTW (10)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_alloc_valid (i_alloc_valid),
      .o_alloc_ready (o_alloc_ready),
      .i_alloc_taken (i_alloc_taken),
      .i_alloc_idx   (i_alloc_idx),
      .i_alloc_hist  (i_alloc_hist),
      .o_alloc_tag   (o_alloc_tag),
      .i_res_valid   (i_res_valid),
      .i_res_tag     (i_res_tag),
      .i_res_taken   (i_res_taken),
      .o_upd_valid   (o_upd_valid),
      .o_upd_idx     (o_upd_idx),
      .o_upd_taken   (o_upd_taken),
      .o_flush       (o_flush),
      .o_flush_hist  (o_flush_hist),
      .o_empty       (o_empty)
`ifdef BRQ_STATS_EN
      ,
      .o_stat_branches (o_stat_branches),
      .o_stat_mispred  (o_stat_mispred)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_alloc_valid = 1'b0;
      i_alloc_taken = 1'b0;
      i_alloc_idx   = '0;
      i_alloc_hist  = '0;
      i_res_valid   = 1'b0;
      i_res_tag     = '0;
      i_res_taken   = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
   endtask

   task automatic alloc1(input logic taken, input logic [9:0] idx, input logic [9:0] hist,
                         input int exp_tag);
      chk("alloc_tag", 32'(o_alloc_tag), 32'(exp_tag));
      i_alloc_valid = 1'b1;
      i_alloc_taken = taken;
      i_alloc_idx   = idx;
      i_alloc_hist  = hist;
      step();
      i_alloc_valid = 1'b0;
   endtask

   initial begin
      // ---------------- reset state
      idle();
      i_reset = 1'b1;
      #1;
      chk("rst_alloc_ready", 32'(o_alloc_ready), 32'd1);
      chk("rst_empty",       32'(o_empty),       32'd1);
      chk("rst_alloc_tag",   32'(o_alloc_tag),   32'd0);
      chk("rst_upd_valid",   32'(o_upd_valid),   32'd0);
      chk("rst_upd_idx",     32'(o_upd_idx),     32'd0);
      chk("rst_upd_taken",   32'(o_upd_taken),   32'd0);
      chk("rst_flush",       32'(o_flush),       32'd0);
      chk("rst_flush_hist",  32'(o_flush_hist),  32'd0);
      step();
      i_reset = 1'b0;

      // ---------------- out-of-order resolve, in-order update
      for (int k = 0; k < 3; k++) alloc1(1'b1, 10'(32'h010 + k), 10'h000, k);
      chk("ooo_empty", 32'(o_empty), 32'd0);
      i_res_valid = 1'b1; i_res_taken = 1'b1;
      i_res_tag = 3'd2; step();
      chk("ooo_upd0", 32'(o_upd_valid), 32'd0);
      i_res_tag = 3'd0; step();
      chk("ooo_upd1", 32'(o_upd_valid), 32'd0);
      i_res_tag = 3'd1; step();
      i_res_valid = 1'b0;
      chk("ooo_t0_valid", 32'(o_upd_valid), 32'd1);
      chk("ooo_t0_idx",   32'(o_upd_idx),   32'h010);
      chk("ooo_t0_taken", 32'(o_upd_taken), 32'd1);
      step();
      chk("ooo_t1_valid", 32'(o_upd_valid), 32'd1);
      chk("ooo_t1_idx",   32'(o_upd_idx),   32'h011);
      step();
      chk("ooo_t2_valid", 32'(o_upd_valid), 32'd1);
      chk("ooo_t2_idx",   32'(o_upd_idx),   32'h012);
      chk("ooo_flush",    32'(o_flush),     32'd0);
      step();
      chk("ooo_idle_valid", 32'(o_upd_valid), 32'd0);
      chk("ooo_hold_idx",   32'(o_upd_idx),   32'h012);
      chk("ooo_empty_end",  32'(o_empty),     32'd1);

      // ---------------- full queue
      do_reset();
      for (int k = 0; k < 8; k++) alloc1(1'b0, 10'(32'h100 + k), 10'h000, k);
      chk("full_ready", 32'(o_alloc_ready), 32'd0);
      i_alloc_valid = 1'b1; i_alloc_idx = 10'h3FF;
      step();
      chk("full_ignored_tag", 32'(o_alloc_tag),   32'd0);
      chk("full_ready2",      32'(o_alloc_ready), 32'd0);
      // alloc_valid stays high across the retire cycle; count is still 8 then
      i_res_valid = 1'b1; i_res_tag = 3'd0; i_res_taken = 1'b0;
      step();
      i_res_valid = 1'b0;
      chk("full_ready3", 32'(o_alloc_ready), 32'd0);
      step();
      i_alloc_valid = 1'b0;
      chk("full_ret_valid", 32'(o_upd_valid),   32'd1);
      chk("full_ret_idx",   32'(o_upd_idx),     32'h100);
      chk("full_ret_taken", 32'(o_upd_taken),   32'd0);
      chk("full_ready4",    32'(o_alloc_ready), 32'd1);
      chk("full_tag_held",  32'(o_alloc_tag),   32'd0);
      step();
      chk("full_hold_valid", 32'(o_upd_valid), 32'd0);
      chk("full_hold_idx",   32'(o_upd_idx),   32'h100);

      // ---------------- mispredict squashes younger entries
      do_reset();
      alloc1(1'b1, 10'h020, 10'h000, 0);
      alloc1(1'b1, 10'h021, 10'h155, 1);
      alloc1(1'b1, 10'h022, 10'h000, 2);
      alloc1(1'b1, 10'h023, 10'h000, 3);
      i_res_valid = 1'b1; i_res_tag = 3'd1; i_res_taken = 1'b0;
      step();
      chk("mp_flush",      32'(o_flush),      32'd1);
      chk("mp_flush_hist", 32'(o_flush_hist), 32'h2AA);
      chk("mp_tail",       32'(o_alloc_tag),  32'd2);
      // tag 3 is gone, so a disagreeing resolution for it must do nothing
      i_res_tag = 3'd3; i_res_taken = 1'b0;
      step();
      chk("mp_flush_once", 32'(o_flush), 32'd0);
      i_res_tag = 3'd0; i_res_taken = 1'b1;
      step();
      i_res_valid = 1'b0;
      chk("mp_stale_flush", 32'(o_flush),     32'd0);
      chk("mp_upd_none",    32'(o_upd_valid), 32'd0);
      step();
      chk("mp_t0_valid", 32'(o_upd_valid), 32'd1);
      chk("mp_t0_idx",   32'(o_upd_idx),   32'h020);
      step();
      chk("mp_t1_valid", 32'(o_upd_valid), 32'd1);
      chk("mp_t1_idx",   32'(o_upd_idx),   32'h021);
      chk("mp_t1_taken", 32'(o_upd_taken), 32'd0);
      step();
      chk("mp_done_valid", 32'(o_upd_valid), 32'd0);
      chk("mp_done_empty", 32'(o_empty),     32'd1);
`ifdef BRQ_STATS_EN
      chk("mp_stat_br", o_stat_branches, 32'd2);
      chk("mp_stat_mp", o_stat_mispred,  32'd1);
`endif

      // ---------------- allocation dropped by a same-cycle mispredict
      do_reset();
      alloc1(1'b1, 10'h030, 10'h001, 0);
      i_alloc_valid = 1'b1; i_alloc_idx = 10'h031; i_alloc_taken = 1'b1;
      i_res_valid = 1'b1; i_res_tag = 3'd0; i_res_taken = 1'b0;
      step();
      i_alloc_valid = 1'b0;
      chk("drop_flush",      32'(o_flush),      32'd1);
      chk("drop_flush_hist", 32'(o_flush_hist), 32'h002);
      chk("drop_tail",       32'(o_alloc_tag),  32'd1);
      i_res_tag = 3'd1; i_res_taken = 1'b0;
      step();
      i_res_valid = 1'b0;
      chk("drop_upd_valid", 32'(o_upd_valid), 32'd1);
      chk("drop_upd_idx",   32'(o_upd_idx),   32'h030);
      chk("drop_no_flush",  32'(o_flush),     32'd0);
      step();
      chk("drop_empty",   32'(o_empty),     32'd1);
      chk("drop_tail2",   32'(o_alloc_tag), 32'd1);
      chk("drop_no_upd",  32'(o_upd_valid), 32'd0);
      chk("drop_flush2",  32'(o_flush),     32'd0);

      // ---------------- tail wrap with interleaved retires
      do_reset();
      for (int k = 0; k < 10; k++) begin
         chk("wrap_tag", 32'(o_alloc_tag), 32'(k % 8));
         i_alloc_valid = 1'b1;
         i_alloc_taken = 1'b1;
         i_alloc_idx   = 10'(32'h040 + k);
         i_res_valid   = (k == 1) || (k == 2);
         i_res_tag     = 3'(k - 1);
         i_res_taken   = 1'b1;
         step();
         if (k == 2) chk("wrap_upd_t0", 32'(o_upd_idx), 32'h040);
         if (k == 3) chk("wrap_upd_t1", 32'(o_upd_idx), 32'h041);
         if (k == 4) chk("wrap_upd_none", 32'(o_upd_valid), 32'd0);
      end
      idle();
      chk("wrap_full", 32'(o_alloc_ready), 32'd0);
      for (int j = 0; j < 8; j++) begin
         i_res_valid = 1'b1;
         i_res_tag   = 3'((2 + j) % 8);
         i_res_taken = 1'b1;
         step();
         if (j > 0) begin
            chk("wrap_upd_valid", 32'(o_upd_valid), 32'd1);
            chk("wrap_upd_idx",   32'(o_upd_idx),   32'(32'h041 + j));
         end
      end
      i_res_valid = 1'b0;
      step();
      chk("wrap_last_idx", 32'(o_upd_idx), 32'h049);
      step();
      chk("wrap_empty", 32'(o_empty), 32'd1);
      chk("wrap_flush", 32'(o_flush), 32'd0);

      // ---------------- reset with entries in flight
      do_reset();
      for (int k = 0; k < 5; k++) alloc1(1'b1, 10'(32'h050 + k), 10'h000, k);
      i_res_valid = 1'b1; i_res_tag = 3'd0; i_res_taken = 1'b1;
      step();
      // tag 0 would retire next edge; tag 2 is mispredicting right now
      i_res_tag = 3'd2; i_res_taken = 1'b0;
      #2;
      i_reset = 1'b1;
      #1;
      chk("arst_empty",     32'(o_empty),       32'd1);
      chk("arst_ready",     32'(o_alloc_ready), 32'd1);
      chk("arst_tag",       32'(o_alloc_tag),   32'd0);
      idle();
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("arst_no_upd",   32'(o_upd_valid), 32'd0);
         chk("arst_no_flush", 32'(o_flush),     32'd0);
      end
      chk("arst_empty2", 32'(o_empty), 32'd1);
`ifdef BRQ_STATS_EN
      chk("arst_stat_br", o_stat_branches, 32'd0);
      chk("arst_stat_mp", o_stat_mispred,  32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
